// File: rtl/seg_flow_scheduler.sv
// Per-flow descriptor scheduler: queues {last, ptr} descriptors per flow and grants the read engine one
// flow at a time at packet granularity. Define SEG_SCHED_STRICT_PRIO_EN for strict-priority arbitration.
module seg_flow_scheduler #(
    parameter  int NUM_FLOWS    = 4,
    parameter  int BUF_SEG_AW   = 10,
    parameter  int DESC_DEPTH_W = 4,
    localparam int FLOW_W       = $clog2(NUM_FLOWS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [FLOW_W-1:0]     desc_flow,
    input  logic [BUF_SEG_AW-1:0] desc_ptr,
    input  logic                  desc_last,
    input  logic [NUM_FLOWS-1:0]  flow_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUF_SEG_AW-1:0] out_ptr,
    output logic                  out_last,
    output logic [FLOW_W-1:0]     out_flow,
    output logic [NUM_FLOWS-1:0]  flow_nonempty,
    output logic                  sched_locked
);

    localparam int DEPTH = 1 << DESC_DEPTH_W;
    localparam int CNT_W = DESC_DEPTH_W + 1;
    localparam int ENT_W = BUF_SEG_AW + 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0]        mem    [NUM_FLOWS][DEPTH];
    logic [DESC_DEPTH_W-1:0] wr_ptr [NUM_FLOWS];
    logic [DESC_DEPTH_W-1:0] rd_ptr [NUM_FLOWS];
    logic [CNT_W-1:0]        count  [NUM_FLOWS];
    logic [CNT_W-1:0]        count_nxt [NUM_FLOWS];

    logic [NUM_FLOWS-1:0] full;
    logic [NUM_FLOWS-1:0] eligible;
    logic [NUM_FLOWS-1:0] push_vec;
    logic [NUM_FLOWS-1:0] pop_vec;

    logic                 push;
    logic                 pop;
    logic [ENT_W-1:0]     head;
    logic [FLOW_W-1:0]    grant_flow;
    logic                 found;
    logic [FLOW_W-1:0]    pick;
    logic [BUF_SEG_AW-1:0] hold_ptr;
    logic                 hold_last;

    // Count can only reach DEPTH, so its MSB alone marks a full FIFO.
    always_comb begin
        for (int i = 0; i < NUM_FLOWS; i++) begin
            full[i]     = count[i][DESC_DEPTH_W];
            eligible[i] = flow_en[i] && (count[i] != '0);
            push_vec[i] = push && (desc_flow == FLOW_W'(i));
            pop_vec[i]  = pop && (grant_flow == FLOW_W'(i));
        end
    end

    assign desc_ready = !full[desc_flow];
    assign push       = desc_valid && desc_ready;
    assign head       = mem[grant_flow][rd_ptr[grant_flow]];

    assign sched_locked = (state == S_LOCKED);
    assign out_valid    = sched_locked && (count[grant_flow] != '0);
    assign pop          = out_valid && out_ready;
    assign out_flow     = grant_flow;
    assign out_ptr      = out_valid ? head[BUF_SEG_AW-1:0] : hold_ptr;
    assign out_last     = out_valid ? head[BUF_SEG_AW]     : hold_last;

    // NOTE: descriptor storage has no reset; counts and pointers gate every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[desc_flow][wr_ptr[desc_flow]] <= {desc_last, desc_ptr};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FLOWS; i++) begin
            count_nxt[i] = count[i];
            case ({push_vec[i], pop_vec[i]})
                2'b10:   count_nxt[i] = count[i] + CNT_W'(1);
                2'b01:   count_nxt[i] = count[i] - CNT_W'(1);
                default: count_nxt[i] = count[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            flow_nonempty <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + DESC_DEPTH_W'(1);
                if (pop_vec[i])  rd_ptr[i] <= rd_ptr[i] + DESC_DEPTH_W'(1);
                count[i]         <= count_nxt[i];
                flow_nonempty[i] <= (count_nxt[i] != '0);
            end
        end
    end

`ifdef SEG_SCHED_STRICT_PRIO_EN
    // Descending scan so the lowest-numbered eligible flow is the last to overwrite pick.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                pick  = FLOW_W'(i);
            end
        end
    end
`else
    logic [FLOW_W-1:0] rr_ptr;

    // Offset NUM_FLOWS wraps back to rr_ptr itself, so the last winner is considered last.
    always_comb begin
        logic [FLOW_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_FLOWS; k++) begin
            idx = rr_ptr + FLOW_W'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= FLOW_W'(NUM_FLOWS - 1);
        end else if (state == S_IDLE && found) begin
            rr_ptr <= pick;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (found) state_nxt = S_LOCKED;
            S_LOCKED: if (pop && head[BUF_SEG_AW]) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            grant_flow <= '0;
            hold_ptr   <= '0;
            hold_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && found) begin
                grant_flow <= pick;
            end
            if (pop) begin
                hold_ptr  <= head[BUF_SEG_AW-1:0];
                hold_last <= head[BUF_SEG_AW];
            end
        end
    end

endmodule
